// File: rtl/irq_aggregator_pkg.sv
// irq_aggregator_pkg: shared register map, widths and the priority-encode helper for irq_aggregator.
package irq_aggregator_pkg;

   localparam int MAX_SRC      = 16;
   localparam int ID_VALID_BIT = 15;

   localparam logic [2:0] ADDR_STATUS  = 3'd0;
   localparam logic [2:0] ADDR_PENDING = 3'd1;
   localparam logic [2:0] ADDR_MASK    = 3'd2;
   localparam logic [2:0] ADDR_EDGE    = 3'd3;
   localparam logic [2:0] ADDR_ID      = 3'd4;
   localparam logic [2:0] ADDR_RAW     = 3'd5;

   typedef logic [2:0]  addr_t;
   typedef logic [15:0] word_t;

   // Index of the lowest set bit; 0 when nothing is set.
   function automatic logic [3:0] prio_id(input word_t v);
      prio_id = '0;
      for (int i = MAX_SRC - 1; i >= 0; i--)
         if (v[i]) prio_id = 4'(i);
   endfunction

endpackage

// File: rtl/irq_aggregator_if.sv
// irq_aggregator_if: Avalon-MM slave register bus of the interrupt aggregator.
interface irq_aggregator_if;
   import irq_aggregator_pkg::*;

   logic  chipselect;
   addr_t address;
   logic  write_n;
   word_t writedata;
   word_t readdata;

   modport master (output chipselect, address, write_n, writedata, input readdata);
   modport slave  (input chipselect, address, write_n, writedata, output readdata);

endinterface

// File: rtl/irq_aggregator_sync.sv
// irq_aggregator_sync: W-wide, STAGES-deep reset-to-0 synchronizer chain (STAGES=0 passes through).
module irq_aggregator_sync
   import irq_aggregator_pkg::*;
#(
   parameter int W      = 8,
   parameter int STAGES = 2
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   if (STAGES == 0) begin : g_bypass
      assign q = d;
   end else begin : g_chain
      logic [STAGES-1:0][W-1:0] stage_q, stage_d;

      // Each stage takes the value of the one before it; stage 0 samples the raw input.
      always_comb begin
         stage_d[0] = d;
         for (int i = 1; i < STAGES; i++) stage_d[i] = stage_q[i-1];
      end

      // Reset clears the whole chain so no stale level or edge survives a reset.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) stage_q <= '0;
         else          stage_q <= stage_d;
      end

      assign q = stage_q[STAGES-1];
   end

endmodule

// File: rtl/irq_aggregator.sv
// irq_aggregator: synchronizes, latches, masks and priority-encodes up to 16 interrupt sources.
// Define IRQ_AGGREGATOR_EDGE_EN to make per-source rising-edge mode (EDGE register) available.
module irq_aggregator
   import irq_aggregator_pkg::*;
#(
   parameter int NUM_SRC     = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NUM_SRC-1:0] irq_in,
   irq_aggregator_if.slave    bus,
   output logic               irq_out,
   output logic               irq_valid,
   output logic [3:0]         irq_id
);

   logic [NUM_SRC-1:0] sync, status, edge_rd;
   logic [NUM_SRC-1:0] pending_q, pending_d, mask_q, mask_d;
   word_t              readdata_q, readdata_d, id_word;
   logic               irq_out_q, irq_out_d, irq_valid_q, irq_valid_d;
   logic [3:0]         irq_id_q, irq_id_d;
   logic               wr, rd;
   logic               unused_ok;

   irq_aggregator_sync #(.W(NUM_SRC), .STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (irq_in),
      .q       (sync)
   );

   assign wr        = bus.chipselect & ~bus.write_n;
   assign rd        = bus.chipselect & bus.write_n;
   assign status    = pending_q & mask_q;
   assign unused_ok = ^bus.writedata;

`ifdef IRQ_AGGREGATOR_EDGE_EN
   logic [NUM_SRC-1:0] edge_q, edge_d, prev_q, prev_d, clr;

   // Edge bits hold a rising edge until W1C, ID ack or a 0->1 EDGE switch clears it; a new edge beats any clear.
   always_comb begin
      prev_d    = sync;
      edge_d    = (wr && bus.address == ADDR_EDGE) ? bus.writedata[NUM_SRC-1:0] : edge_q;
      clr       = ((wr && bus.address == ADDR_PENDING) ? bus.writedata[NUM_SRC-1:0] : '0)
                | ((wr && bus.address == ADDR_ID) ? NUM_SRC'(1) << bus.writedata[3:0] : '0)
                | (edge_d & ~edge_q);
      pending_d = (edge_d & ((pending_q & ~clr) | (sync & ~prev_q))) | (~edge_d & sync);
   end

   // Edge-mode state: mode bits and the previous synchronized level.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         edge_q <= '0;
         prev_q <= '0;
      end else begin
         edge_q <= edge_d;
         prev_q <= prev_d;
      end
   end

   assign edge_rd = edge_q;
`else
   assign pending_d = sync;
   assign edge_rd   = '0;
`endif

   // Mask writes, priority encode over masked pending, and the registered read mux.
   always_comb begin
      mask_d                = (wr && bus.address == ADDR_MASK) ? bus.writedata[NUM_SRC-1:0] : mask_q;
      irq_out_d             = |status;
      irq_valid_d           = |status;
      irq_id_d              = prio_id(MAX_SRC'(status));
      id_word               = '0;
      id_word[ID_VALID_BIT] = irq_valid_q;
      id_word[3:0]          = irq_id_q;
      readdata_d            = !rd                          ? readdata_q
                            : bus.address == ADDR_STATUS  ? MAX_SRC'(status)
                            : bus.address == ADDR_PENDING ? MAX_SRC'(pending_q)
                            : bus.address == ADDR_MASK    ? MAX_SRC'(mask_q)
                            : bus.address == ADDR_EDGE    ? MAX_SRC'(edge_rd)
                            : bus.address == ADDR_ID      ? id_word
                            : bus.address == ADDR_RAW     ? MAX_SRC'(sync)
                            : '0;
   end

   // Main state registers, all cleared asynchronously.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending_q   <= '0;
         mask_q      <= '0;
         readdata_q  <= '0;
         irq_out_q   <= 1'b0;
         irq_valid_q <= 1'b0;
         irq_id_q    <= '0;
      end else begin
         pending_q   <= pending_d;
         mask_q      <= mask_d;
         readdata_q  <= readdata_d;
         irq_out_q   <= irq_out_d;
         irq_valid_q <= irq_valid_d;
         irq_id_q    <= irq_id_d;
      end
   end

   assign bus.readdata = readdata_q;
   assign irq_out      = irq_out_q;
   assign irq_valid    = irq_valid_q;
   assign irq_id       = irq_id_q;

endmodule

// File: tb/tb_irq_aggregator.sv
// tb_irq_aggregator: directed plus randomized bench with a queue-based scoreboard and behavioural model.
module tb_irq_aggregator;
   import irq_aggregator_pkg::*;

   localparam int NS = 8;
   localparam int SS = 2;
`ifdef IRQ_AGGREGATOR_EDGE_EN
   localparam bit EDGE_EN = 1'b1;
`else
   localparam bit EDGE_EN = 1'b0;
`endif

   typedef struct packed {
      logic       o;
      logic       v;
      logic [3:0] id;
   } out_t;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [NS-1:0] irq_in;
   logic          irq_out, irq_valid;
   logic [3:0]    irq_id;

   irq_aggregator_if bus();

   irq_aggregator #(.NUM_SRC(NS), .SYNC_STAGES(SS)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .irq_in    (irq_in),
      .bus       (bus),
      .irq_out   (irq_out),
      .irq_valid (irq_valid),
      .irq_id    (irq_id)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   out_t          out_q[$];
   logic [15:0]   rd_q[$];

   logic [NS-1:0] m_pend, m_mask, m_edge, m_prev;
   logic          m_valid;
   logic [3:0]    m_id;
   logic [NS-1:0] hist[$];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
      end
   endtask

   function automatic int lowest(input logic [NS-1:0] v);
      for (int i = 0; i < NS; i++) if (v[i]) return i;
      return 0;
   endfunction

   task automatic model_reset();
      m_pend = '0; m_mask = '0; m_edge = '0; m_prev = '0;
      m_valid = 1'b0; m_id = '0;
      hist.delete();
      repeat (SS) hist.push_back('0);
   endtask

   // Predicts the effect of the coming clock edge from the inputs currently driven.
   task automatic model_step();
      logic [NS-1:0] sync, stat, np, ne;
      logic          wr, rd;
      logic [2:0]    a;
      logic [15:0]   wd, rv;
      out_t          e;
      if (!reset_n) begin
         model_reset();
         out_q.push_back('0);
         return;
      end
      sync = hist[0];
      stat = m_pend & m_mask;
      a    = bus.address;
      wd   = bus.writedata;
      wr   = bus.chipselect && !bus.write_n;
      rd   = bus.chipselect && bus.write_n;
      if (rd) begin
         case (a)
            ADDR_STATUS:  rv = {8'h00, stat};
            ADDR_PENDING: rv = {8'h00, m_pend};
            ADDR_MASK:    rv = {8'h00, m_mask};
            ADDR_EDGE:    rv = {8'h00, m_edge};
            ADDR_ID:      rv = {m_valid, 11'd0, m_id};
            ADDR_RAW:     rv = {8'h00, sync};
            default:      rv = 16'h0000;
         endcase
         rd_q.push_back(rv);
      end
      e.o  = stat != 0;
      e.v  = stat != 0;
      e.id = stat != 0 ? 4'(lowest(stat)) : 4'd0;
      ne   = (EDGE_EN && wr && a == ADDR_EDGE) ? wd[NS-1:0] : m_edge;
      for (int i = 0; i < NS; i++) begin
         if (!ne[i]) np[i] = sync[i];
         else if (sync[i] && !m_prev[i]) np[i] = 1'b1;
         else if ((wr && a == ADDR_PENDING && wd[i]) || (wr && a == ADDR_ID && wd[3:0] == i) ||
                  (wr && a == ADDR_EDGE && wd[i] && !m_edge[i])) np[i] = 1'b0;
         else np[i] = m_pend[i];
      end
      if (wr && a == ADDR_MASK) m_mask = wd[NS-1:0];
      m_pend  = np;
      m_edge  = ne;
      m_prev  = sync;
      m_valid = e.v;
      m_id    = e.id;
      void'(hist.pop_front());
      hist.push_back(irq_in);
      out_q.push_back(e);
   endtask

   task automatic idle();
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.address    = '0;
      bus.writedata  = '0;
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) cycle();
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
      bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = a; bus.writedata = d;
      cycle();
      idle();
   endtask

   task automatic bus_read(input logic [2:0] a);
      bus.chipselect = 1'b1; bus.write_n = 1'b1; bus.address = a;
      cycle();
      idle();
   endtask

   task automatic mid_reset();
      #2;
      reset_n = 1'b0;
      irq_in  = '0;
      idle();
      #1;
      check("async_rst_irq_out", irq_out, 0);
      check("async_rst_irq_valid", irq_valid, 0);
      check("async_rst_irq_id", irq_id, 0);
      check("async_rst_readdata", bus.readdata, 0);
      model_reset();
      wait_cycles(2);
      reset_n = 1'b1;
   endtask

   // Monitor: pops the expected outputs of every edge and the expected read data after each read.
   initial begin
      out_t e;
      logic rd_seen;
      forever begin
         @(posedge clk);
         rd_seen = reset_n && bus.chipselect && bus.write_n;
         #2;
         if (out_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL out_queue: got empty expected an entry");
         end else begin
            e = out_q.pop_front();
            check("irq_out", irq_out, e.o);
            check("irq_valid", irq_valid, e.v);
            check("irq_id", irq_id, e.id);
         end
         if (rd_seen) begin
            if (rd_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL rd_queue: got empty expected an entry");
            end else check("readdata", bus.readdata, rd_q.pop_front());
         end
      end
   end

   initial begin
      reset_n = 1'b0;
      irq_in  = '0;
      idle();
      model_reset();
      wait_cycles(3);
      check("reset_readdata", bus.readdata, 0);
      check("reset_irq_out", irq_out, 0);
      reset_n = 1'b1;
      wait_cycles(2);

      // Level source 2
      bus_write(ADDR_MASK, 16'h0004);
      irq_in = 8'h04;
      wait_cycles(3);
      check("level_lat3", irq_out, 0);
      cycle();
      check("level_lat4", irq_out, 1);
      bus_read(ADDR_ID);
      check("level_id", bus.readdata, 16'h8002);
      irq_in = 8'h00;
      wait_cycles(4);
      check("level_drop", irq_out, 0);

      // Edge source 0
      bus_write(ADDR_EDGE, 16'h0001);
      bus_write(ADDR_MASK, 16'h0001);
      irq_in = 8'h01;
      wait_cycles(3);
      irq_in = 8'h00;
      wait_cycles(4);
      bus_read(ADDR_PENDING);
`ifdef IRQ_AGGREGATOR_EDGE_EN
      check("edge_pending", bus.readdata, 16'h0001);
`endif
      bus_write(ADDR_ID, 16'h0000);
      cycle();
      check("edge_ack_out", irq_out, 0);

      // Priority between sources 3 and 5
      bus_write(ADDR_EDGE, 16'h00FF);
      bus_write(ADDR_MASK, 16'h00FF);
      irq_in = 8'h28;
      wait_cycles(4);
      bus_read(ADDR_ID);
      check("prio_id3", bus.readdata, 16'h8003);
      irq_in = 8'h00;
      bus_write(ADDR_ID, 16'h0003);
      cycle();
      bus_read(ADDR_ID);
`ifdef IRQ_AGGREGATOR_EDGE_EN
      check("prio_id5", bus.readdata, 16'h8005);
`endif
      bus_write(ADDR_ID, 16'h0005);
      cycle();
      bus_read(ADDR_ID);
      check("prio_none", bus.readdata, 16'h0000);
      wait_cycles(3);

      // Set/clear collision on source 1
      irq_in = 8'h02;
      wait_cycles(2);
      bus_write(ADDR_PENDING, 16'h0002);
      bus_read(ADDR_PENDING);
      check("collision_pending", bus.readdata, 16'h0002);
      irq_in = 8'h00;
      wait_cycles(3);

      // Masked pending on source 6
      bus_write(ADDR_PENDING, 16'h00FF);
      bus_write(ADDR_MASK, 16'h0000);
      irq_in = 8'h40;
      wait_cycles(3);
      irq_in = 8'h00;
      wait_cycles(2);
      bus_read(ADDR_PENDING);
`ifdef IRQ_AGGREGATOR_EDGE_EN
      check("masked_pending", bus.readdata, 16'h0040);
`endif
      bus_read(ADDR_STATUS);
      check("masked_status", bus.readdata, 16'h0000);
      check("masked_out", irq_out, 0);
      bus_write(ADDR_MASK, 16'h0040);
      cycle();
`ifdef IRQ_AGGREGATOR_EDGE_EN
      check("unmask_out", irq_out, 1);
`endif
      bus_read(ADDR_RAW);
      bus_read(3'd6);

      // Reset with all sources pending
      bus_write(ADDR_MASK, 16'h00FF);
      irq_in = 8'hFF;
      wait_cycles(4);
      bus_read(ADDR_PENDING);
      check("full_pending", bus.readdata, 16'h00FF);
      mid_reset();
      wait_cycles(4);
      bus_read(ADDR_PENDING);
      check("post_reset_pending", bus.readdata, 16'h0000);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         int r;
         if ($urandom_range(0, 5) == 0) irq_in = 8'($urandom);
         if (i == 1500) mid_reset();
         r = $urandom_range(0, 9);
         case (r)
            0, 1, 2: bus_read(3'($urandom_range(0, 7)));
            3:       bus_write(ADDR_MASK, 16'($urandom));
            4:       bus_write(ADDR_EDGE, 16'($urandom));
            5:       bus_write(ADDR_PENDING, 16'($urandom));
            6:       bus_write(ADDR_ID, 16'($urandom_range(0, 15)));
            7:       bus_write(3'($urandom_range(0, 7)), 16'($urandom));
            default: cycle();
         endcase
      end

      #5;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
